// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and a sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_pkg;

    // FSM state encoding shared by the top and any observer logic.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the digit counter; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// DIGIT-bit ripple-borrow subtract slice: {bout, diff} = a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic br;

    // Ripple the borrow from the LSB upward, one full-subtractor per bit.
    always_comb begin
        br   = bin;
        diff = '0;
        for (int i = 0; i < DIGIT; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bin), DIGIT bits per cycle, LSB digit first.
// Latency: accept at edge N, out_valid after edge N+STEPS; issue interval STEPS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. SERIAL_SUB_SAT_EN saturates diff at 0.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    // Operands must split into whole digits; refuse to elaborate otherwise.
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
        $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             out_vld_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic             bo_dig;

    // Pick the current digit of each latched operand for the shared slice.
    always_comb begin
        a_dig = a_q[cnt_q * DIGIT +: DIGIT];
        b_dig = b_q[cnt_q * DIGIT +: DIGIT];
    end

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .bin  (brw_q),
        .diff (d_dig),
        .bout (bo_dig)
    );

    // Control FSM plus datapath registers; diff only changes while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q[cnt_q * DIGIT +: DIGIT] <= d_dig;
                    brw_q <= bo_dig;
                    if (cnt_q == LAST) begin
                        cnt_q     <= '0;
                        bout_q    <= bo_dig;
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
`ifdef SERIAL_SUB_SAT_EN
                        // Underflow clamps to zero; the borrow still reports it.
                        if (bo_dig) begin
                            diff_q <= '0;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Ready is masked by reset so nothing is accepted in the reset cycle.
    always_comb begin
        in_ready  = (state_q == IDLE) & ~rst;
        busy      = (state_q != IDLE);
        out_valid = out_vld_q;
        diff      = diff_q;
        bout      = bout_q;
    end

endmodule
